// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-RAM access sequencer: funct3 codes,
// FSM encoding and the default bus timeout.
package mem_access_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load formatter: picks the byte/half addressed within the RAM word and
// sign- or zero-extends it according to funct3.
module load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: validates load/store requests, issues one
// byte-strobed word transaction to the data RAM and stalls until it retires.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_wstrb,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,
    output logic        ms_stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        acc_fault,
    output logic        bus_err
);

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  alo_q;
    logic [31:0] fmt_data;
    logic        f3_ok, aligned, req_ok;
    logic        start, finish_ok, timeout;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;

    load_align u_load_align (
        .rdata   (ram_rdata),
        .funct3  (f3_q),
        .addr_lo (alo_q),
        .data    (fmt_data)
    );

    // Request decode; stores only accept the signed-size encodings.
    always_comb begin
        f3_ok = mem_write ? (funct3 inside {F3_B, F3_H, F3_W})
                          : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        case (funct3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        req_ok = (mem_read ^ mem_write) && f3_ok && aligned;
        case (funct3[1:0])
            2'b00: begin
                wstrb_n = 4'b0001 << addr[1:0];
                wdata_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb_n = 4'b0011 << addr[1:0];
                wdata_n = {2{wdata[15:0]}};
            end
            default: begin
                wstrb_n = 4'hF;
                wdata_n = wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ms_stall  = 1'b0;
        acc_fault = 1'b0;
        start     = 1'b0;
        finish_ok = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_ok) begin
                    state_n  = ST_BUSY;
                    ms_stall = 1'b1;
                    start    = 1'b1;
                end else if (mem_read || mem_write) begin
                    acc_fault = 1'b1;
                end
            end
            ST_BUSY: begin
                ms_stall = 1'b1;
                // ready on the last allowed cycle still wins over the timeout
                if (ram_req && ram_ready) begin
                    state_n   = ST_DONE;
                    finish_ok = 1'b1;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state_n = ST_DONE;
                    timeout = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wstrb <= '0;
            ram_wdata <= '0;
            f3_q      <= '0;
            alo_q     <= '0;
            cnt       <= '0;
            ld_valid  <= 1'b0;
            ld_data   <= '0;
            bus_err   <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            bus_err  <= 1'b0;
            if (state == ST_BUSY) cnt <= cnt + 8'd1;
            if (start) begin
                ram_req   <= 1'b1;
                ram_we    <= mem_write;
                ram_addr  <= {addr[31:2], 2'b00};
                ram_wstrb <= mem_write ? wstrb_n : 4'h0;
                ram_wdata <= wdata_n;
                f3_q      <= funct3;
                alo_q     <= addr[1:0];
                cnt       <= '0;
            end
            if (finish_ok) begin
                ram_req  <= 1'b0;
                ld_valid <= ~ram_we;
                if (!ram_we) ld_data <= fmt_data;
            end
            if (timeout) begin
                ram_req <= 1'b0;
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the data RAM behind the memory stage. It turns load/store requests (read/write flag, funct3, address, store data) into word-aligned, byte-strobed RAM transactions with a req/ready handshake. It stalls the pipeline while a transaction is outstanding and returns load data sign- or zero-extended. It sits between the execute/memory pipeline register and the data RAM, and replaces the direct RAM-data passthrough.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum cycles waiting for `ram_ready` before aborting with a bus error (2..255).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_read` in 1: load requested this cycle.
- `mem_write` in 1: store requested this cycle.
- `funct3` in 3: access size/sign (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data, value in low bits.
- `ram_req` out 1: RAM request, held until `ram_ready`.
- `ram_we` out 1: write enable.
- `ram_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `ram_wstrb` out 4: byte strobes.
- `ram_wdata` out 32: store data replicated to lanes.
- `ram_rdata` in 32: read data, valid when `ram_ready`.
- `ram_ready` in 1: RAM completes the transaction this cycle.
- `ms_stall` out 1: hold upstream stages.
- `ld_valid` out 1: one-cycle pulse; `ld_data` valid.
- `ld_data` out 32: formatted load result.
- `acc_fault` out 1: one-cycle pulse for misaligned, illegal funct3, or read and write both set.
- `bus_err` out 1: one-cycle pulse on timeout.

## Operation
- States: IDLE, BUSY, DONE. Encoding is 2 bits.
- **IDLE, valid request.** A request is valid when exactly one of `mem_read`/`mem_write` is set, funct3 is legal for that op, and the address is aligned (half: `addr[0]=0`; word: `addr[1:0]=0`).
  - Latch `ram_addr`, `ram_we`, `ram_wstrb`, `ram_wdata`, funct3 and `addr[1:0]`.
  - Go to BUSY. `ms_stall=1` combinationally in this cycle.
- **IDLE, bad request.** An illegal or misaligned request pulses `acc_fault` in the same cycle. No RAM access is made, `ms_stall=0`, and the FSM stays in IDLE.
- **BUSY.** `ram_req=1` and `ms_stall=1`. The latched fields are stable. A cycle counter starts at 0.
  - On `ram_ready`: capture the formatted load data and go to DONE.
  - If the counter reaches `TIMEOUT-1` without `ram_ready`: pulse `bus_err` on the transition cycle, drop `ram_req`, and go to DONE with `ld_valid=0`.
- **DONE.** `ms_stall=0`. `ld_valid=1` if the access was a completed load. Inputs are ignored (the instruction retires this cycle). Next state is IDLE.
- **Store lanes.**
  - SB: `wstrb = 1<<addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - SH: `wstrb = 4'b0011<<addr[1:0]`, `wdata = {2{wdata[15:0]}}`.
  - SW: `wstrb = 4'hF`.
- **Load format.** Select byte or half by the latched `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `ram_we=0` and `ram_wstrb=0` for loads.

## Timing
- Reset values: state IDLE; `ram_req`, `ram_we`, `ms_stall`, `ld_valid`, `acc_fault`, `bus_err` all 0; `ram_addr`, `ram_wstrb`, `ram_wdata`, `ld_data` all 0.
- Minimum latency with `ram_ready` in the first BUSY cycle: request cycle (stall), BUSY (stall), DONE (result). The pipeline loses 2 cycles.
- `ram_ready` is sampled only while `ram_req=1`. `ram_ready` outside BUSY is ignored.
- `ram_ready` in the same cycle the counter reaches `TIMEOUT-1` counts as success; `bus_err` stays 0.
- Reset asserted mid-BUSY: `ram_req` drops asynchronously, no `ld_valid` or `bus_err` pulse, state goes to IDLE.
- `ld_data` holds its value until the next completed load.
- Only `ms_stall` and `acc_fault` are combinational from inputs. All other outputs are registered.

## Structure
- The shared core package holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - FSM state encoding;
  - the `TIMEOUT` default.
- Sub-module `load_align`: purely combinational. Inputs are `rdata`, `funct3`, and `addr[1:0]`; output is the 32-bit formatted data. Instantiate it once.

## Test plan
- **LW.** `addr=0x100`, RAM returns `0xDEADBEEF` with ready on the 1st BUSY cycle. Expect `ram_addr=0x100`, `ms_stall` for 2 cycles, `ld_valid` with `ld_data=0xDEADBEEF` in the 3rd cycle.
- **LB/LBU.** `addr=0x103`, rdata `0x80112233`:
  - LB gives `0xFFFFFF80`;
  - LBU gives `0x00000080`;
  - LH at `0x102` gives `0xFFFF8011`.
- **SB and SH.**
  - SB: `addr=0x101`, `wdata=0x000000AB`. Expect `wstrb=4'b0010`, `ram_wdata=0xABABABAB`, `ram_we=1`, and no `ld_valid`.
  - SH: `addr=0x102`. Expect `wstrb=4'b1100`.
- **Faults.** Each of LW at `0x102`, LH at `0x101`, and funct3=011 load gives a single `acc_fault` pulse, no `ram_req`, and `ms_stall=0`.
- **Timeout.** With `TIMEOUT=4` and `ram_ready` held low: `ram_req` is high for 4 cycles, then `bus_err` pulses once, and `ms_stall` is released in DONE.
  - Variant: ready arriving on the 4th BUSY cycle gives a normal `ld_valid` and no `bus_err`.
- **Reset mid-BUSY.** Assert `rst_n=0` during BUSY. Expect `ram_req=0` immediately. After release, a new LW completes normally.
